fp32_multiplier: RTL and testbench

Pipelined IEEE-754 binary32 multiplier that accepts one operand pair per clock and returns the product after a fixed latency. Results use round-to-nearest-even with flush-to-zero, and status flags are reported alongside each result. It is a leaf arithmetic block, driven by a valid strobe and consumed through the done strobe.

---
 rtl/fp32_multiplier.sv | 139 +++++++++++++
 tb/tb_fp32_multiplier.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fp32_multiplier.sv
// Pipelined IEEE-754 binary32 multiplier: round-to-nearest-even, DAZ on inputs,
// flush-to-zero on outputs, one operand pair per clock, result three cycles later.
module fp32_multiplier #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             invalid_o
);

  // Returns {normalize_shift, round_carry, mantissa[22:0]} for a 48-bit product
  // of two hidden-one significands; a round carry leaves the mantissa at zero.
  function automatic logic [24:0] round_rne(input logic [47:0] prod);
    logic [22:0] man;
    logic        g, r, s;
    logic [23:0] man_r;
    if (prod[47]) begin
      man = prod[46:24];
      g   = prod[23];
      r   = prod[22];
      s   = |prod[21:0];
    end else begin
      man = prod[45:23];
      g   = prod[22];
      r   = prod[21];
      s   = |prod[20:0];
    end
    man_r = {1'b0, man} + 24'(g & (r | s | man[0]));
    return {prod[47], man_r};
  endfunction

  // Resolves special operands and exponent range into {result, ovf, unf, inv}.
  function automatic logic [34:0] saturate_pack(
    input logic               sign,
    input logic               nan,
    input logic               inf,
    input logic               zero,
    input logic signed [9:0]  exp,
    input logic [22:0]        man
  );
    if (nan)                    return {32'h7FC0_0000, 3'b001};
    else if (inf)               return {sign, 8'hFF, 23'd0, 3'b000};
    else if (zero)              return {sign, 31'd0, 3'b000};
    else if (exp >= 10'sd255)   return {sign, 8'hFF, 23'd0, 3'b100};
    else if (exp <= 10'sd0)     return {sign, 31'd0, 3'b010};
    else                        return {sign, exp[7:0], man, 3'b000};
  endfunction

  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_man, b_man;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [23:0] a_sig, b_sig;

  assign a_exp  = A[30:23];
  assign b_exp  = B[30:23];
  assign a_man  = A[22:0];
  assign b_man  = B[22:0];
  assign a_zero = (a_exp == 8'd0);
  assign b_zero = (b_exp == 8'd0);
  assign a_inf  = (a_exp == 8'hFF) && (a_man == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_man == 23'd0);
  assign a_nan  = (a_exp == 8'hFF) && (a_man != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_man != 23'd0);
  assign a_sig  = {1'b1, a_man};
  assign b_sig  = {1'b1, b_man};

  logic [LATENCY-1:0] vld_p;

  logic               sign_p0, nan_p0, inf_p0, zero_p0;
  logic signed [9:0]  exp_p0;
  logic [47:0]        prod_p0;

  logic               sign_p1, nan_p1, inf_p1, zero_p1;
  logic signed [9:0]  exp_p1;
  logic [22:0]        man_p1;

  logic [34:0]        res_p2;
  logic [24:0]        rnd_p0;

  assign rnd_p0 = round_rne(prod_p0);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) vld_p <= '0;
    else         vld_p <= {vld_p[LATENCY-2:0], valid_i};
  end

  // Stage p0: classify operands, form sign, biased exponent sum and full product
  always_ff @(posedge clk_i) begin
    sign_p0 <= A[31] ^ B[31];
    nan_p0  <= a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
    inf_p0  <= a_inf | b_inf;
    zero_p0 <= a_zero | b_zero;
    exp_p0  <= $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd127;
    prod_p0 <= 48'(a_sig) * 48'(b_sig);
  end

  // Stage p1: normalize and round; both the shift and the carry bump the exponent
  always_ff @(posedge clk_i) begin
    sign_p1 <= sign_p0;
    nan_p1  <= nan_p0;
    inf_p1  <= inf_p0;
    zero_p1 <= zero_p0;
    exp_p1  <= exp_p0 + $signed(10'(rnd_p0[24])) + $signed(10'(rnd_p0[23]));
    man_p1  <= rnd_p0[22:0];
  end

  // Stage p2: special-case priority, overflow to inf, flush-to-zero underflow
  always_ff @(posedge clk_i) begin
    res_p2 <= saturate_pack(sign_p1, nan_p1, inf_p1, zero_p1, exp_p1, man_p1);
  end

  // Output stage: result and flags change only alongside done_o
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      done_o      <= 1'b0;
      result_o    <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      invalid_o   <= 1'b0;
    end else begin
      done_o <= vld_p[LATENCY-1];
      if (vld_p[LATENCY-1]) begin
        result_o    <= res_p2[34:3];
        overflow_o  <= res_p2[2];
        underflow_o <= res_p2[1];
        invalid_o   <= res_p2[0];
      end
    end
  end

endmodule

// File: tb/tb_fp32_multiplier.sv
// Directed and streamed checks of fp32_multiplier against hand values and an
// integer-remainder rounding model.
module tb_fp32_multiplier;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] result_o;
  logic        done_o, overflow_o, underflow_o, invalid_o;

  int total = 0;
  int bad   = 0;

  fp32_multiplier #(.WIDTH(32), .LATENCY(3)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .valid_i     (valid_i),
    .A           (A),
    .B           (B),
    .result_o    (result_o),
    .done_o      (done_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o),
    .invalid_o   (invalid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [34:0] observed();
    return {result_o, overflow_o, underflow_o, invalid_o};
  endfunction

  // Reference: exact integer product, quotient/remainder rounding, {res, ovf, unf, inv}
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic   s, az, ai, an, bz, bi, bn;
    int     ea, eb, e, sh;
    longint p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 23'd0);
    bi = (eb == 255) && (b[22:0] == 23'd0);
    an = (ea == 255) && (a[22:0] != 23'd0);
    bn = (eb == 255) && (b[22:0] != 23'd0);
    if (an || bn || (az && bi) || (ai && bz)) return {32'h7FC0_0000, 3'b001};
    if (ai || bi) return {s, 8'hFF, 23'd0, 3'b000};
    if (az || bz) return {s, 31'd0, 3'b000};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p >= (longint'(1) << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 3'b100};
    if (e <= 0)   return {s, 31'd0, 3'b010};
    return {s, 8'(e), 23'(q), 3'b000};
  endfunction

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated operation: latency, value+flags, single-cycle done, output hold
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [34:0] exp);
    int k;
    @(negedge clk_i);
    A = a;
    B = b;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    k = 0;
    while (!done_o && k < 8) begin
      @(negedge clk_i);
      k++;
    end
    chk({tag, "_latency"}, 35'(k), 35'd3);
    chk(tag, observed(), exp);
    @(negedge clk_i);
    chk({tag, "_pulse"}, 35'(done_o), 35'd0);
    chk({tag, "_hold"}, observed(), exp);
  endtask

  logic [34:0] exp_q[$];
  logic [31:0] ta[14];
  logic [31:0] tb[14];
  logic [31:0] ra, rb;
  int          pulses;
  int          seen;

  initial begin
    // reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_outputs", observed(), 35'd0);
    chk("reset_done", 35'(done_o), 35'd0);
    rstn_i = 1'b1;

    run_op("one_x_one",     32'h3F80_0000, 32'h3F80_0000, {32'h3F80_0000, 3'b000});
    run_op("two_x_negtwo",  32'h4000_0000, 32'hC000_0000, {32'hC080_0000, 3'b000});
    run_op("twelve_sq",     32'h4140_0000, 32'h4140_0000, {32'h4310_0000, 3'b000});
    run_op("half_sq",       32'h3F00_0000, 32'h3F00_0000, {32'h3E80_0000, 3'b000});
    run_op("inf_x_zero",    32'h7F80_0000, 32'h0000_0000, {32'h7FC0_0000, 3'b001});
    run_op("nan_x_one",     32'h7FC0_0001, 32'h3F80_0000, {32'h7FC0_0000, 3'b001});
    run_op("neginf_x_two",  32'hFF80_0000, 32'h4000_0000, {32'hFF80_0000, 3'b000});
    run_op("overflow",      32'h7F00_0000, 32'h4000_0000, {32'h7F80_0000, 3'b100});
    run_op("underflow",     32'h0080_0000, 32'h3F00_0000, {32'h0000_0000, 3'b010});
    run_op("subnorm_daz",   32'h0000_0001, 32'h3F80_0000, {32'h0000_0000, 3'b000});
    run_op("negzero_x_3",   32'h8000_0000, 32'h4040_0000, {32'h8000_0000, 3'b000});
    run_op("rne_ulp",       32'h3F80_0001, 32'h3F80_0001, {32'h3F80_0002, 3'b000});

    // back-to-back stream: 14 directed then 100 random, checked in order
    ta = '{32'h3F80_0000, 32'h4000_0000, 32'h4140_0000, 32'h3F00_0000, 32'h7F80_0000,
           32'h7FC0_0001, 32'hFF80_0000, 32'h7F00_0000, 32'h0080_0000, 32'h3F80_0001,
           32'h3FFF_FFFF, 32'hC0A0_0000, 32'h0000_0000, 32'h3F80_0001};
    tb = '{32'h3F80_0000, 32'hC000_0000, 32'h4140_0000, 32'h3F00_0000, 32'h0000_0000,
           32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h3F00_0000, 32'h3F80_0001,
           32'h3FFF_FFFF, 32'h3E4C_CCCD, 32'hFF80_0000, 32'h3F7F_FFFF};
    pulses = 0;
    for (int i = 0; i < 124; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        if (exp_q.size() != 0) chk($sformatf("stream%0d", pulses), observed(), exp_q.pop_front());
        pulses++;
      end
      if (i < 14) begin
        ra = ta[i];
        rb = tb[i];
      end else begin
        ra = $urandom();
        rb = $urandom();
        if ($urandom_range(3, 0) != 0) ra[30:23] = 8'($urandom_range(194, 60));
        if ($urandom_range(3, 0) != 0) rb[30:23] = 8'($urandom_range(194, 60));
      end
      if (i < 114) begin
        A = ra;
        B = rb;
        valid_i = 1'b1;
        exp_q.push_back(ref_mul(ra, rb));
      end else begin
        valid_i = 1'b0;
      end
    end
    chk("stream_pulses", 35'(pulses), 35'd114);

    // reset with two operations in flight
    run_op("pre_reset", 32'h4000_0000, 32'h4040_0000, {32'h40C0_0000, 3'b000});
    @(negedge clk_i);
    A = 32'h4000_0000;
    B = 32'h4000_0000;
    valid_i = 1'b1;
    @(negedge clk_i);
    A = 32'h7F80_0000;
    B = 32'h0000_0000;
    @(negedge clk_i);
    valid_i = 1'b0;
    rstn_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (done_o) seen++;
    end
    chk("reset_flush_done", 35'(seen), 35'd0);
    chk("reset_flush_outputs", observed(), 35'd0);
    run_op("post_reset", 32'hC040_0000, 32'h3F00_0000, {32'hBFC0_0000, 3'b000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
